// File: rtl/vx_register_file_spawn_copy.sv
// vx_register_file_spawn_copy
// Two-read / one-write register file with a bulk "spawn" copy engine.
// In IDLE the file accepts single writes; a spawn request switches it to
// COPY, where COPY_LANES registers per cycle are loaded from spawn_src_data
// until the whole file has been overwritten. Register 0 is hard-wired zero.
// Reads are registered: indices sampled on a rising edge, data valid after it.
// Optional feature macro: VX_RF_BYPASS_EN (forward same-edge write data to reads).
//
// Handshake: wr_valid/wr_ready and spawn_valid/spawn_ready transfer on the
// rising edge where both are high. A spawn accept beats a simultaneous write;
// that write is dropped even though wr_ready was high, so the driver must keep
// wr_valid up until a cycle in which no spawn is accepted.

module vx_register_file_spawn_copy #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REGS   = 32,
    parameter  int COPY_LANES = 4,
    localparam int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    // single write port
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [IDX_W-1:0]                 wr_rd,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    // registered read ports
    input  logic [IDX_W-1:0]                 rd_src1,
    input  logic [IDX_W-1:0]                 rd_src2,
    output logic [DATA_WIDTH-1:0]            rd_data1,
    output logic [DATA_WIDTH-1:0]            rd_data2,
    // bulk copy
    input  logic                             spawn_valid,
    output logic                             spawn_ready,
    output logic [IDX_W-1:0]                 spawn_src_idx,
    input  logic [COPY_LANES*DATA_WIDTH-1:0] spawn_src_data,
    output logic                             spawn_done,
    output logic                             busy,
    // debug view of the FSM: 0 = IDLE, 1 = COPY
    output logic                             state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - COPY_LANES);
    localparam logic [IDX_W-1:0] STEP     = IDX_W'(COPY_LANES);

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   rd1_q, rd2_q;
    logic [DATA_WIDTH-1:0]   rd1_d, rd2_d;

    logic                    spawn_accept;
    logic                    wr_commit;
    logic                    last_beat;
    logic [IDX_W-1:0]        lane_idx [COPY_LANES];

    // Handshake and control decode; state_q is forced to IDLE by reset, so
    // the ready outputs are already 1 while reset_n is low.
    always_comb begin
        spawn_accept = (state_q == IDLE) && spawn_valid;
        wr_commit    = (state_q == IDLE) && wr_valid && !spawn_valid && (wr_rd != '0);
        last_beat    = (state_q == COPY) && (idx_q == LAST_IDX);
    end

    assign wr_ready      = (state_q == IDLE);
    assign spawn_ready   = (state_q == IDLE);
    assign busy          = (state_q == COPY);
    assign state_dbg     = state_q;
    assign spawn_src_idx = idx_q;
    assign spawn_done    = done_q;
    assign rd_data1      = rd1_q;
    assign rd_data2      = rd2_q;

    // Destination register of every lane in the current copy beat.
    always_comb begin
        for (int l = 0; l < COPY_LANES; l++) begin
            lane_idx[l] = idx_q + IDX_W'(l);
        end
    end

    // Copy FSM: beat index, completion pulse and state in one registered block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    idx_q  <= '0;
                    if (spawn_accept) begin
                        state_q <= COPY;
                    end
                end
                COPY: begin
                    if (last_beat) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + STEP;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Register array: single writes in IDLE, COPY_LANES writes per COPY beat;
    // index 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wr_commit) begin
                regs_q[wr_rd] <= wr_data;
            end
            if (state_q == COPY) begin
                for (int l = 0; l < COPY_LANES; l++) begin
                    if (lane_idx[l] != '0) begin
                        regs_q[lane_idx[l]] <= spawn_src_data[l*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Read-data selection: array contents before this edge, r0 reads zero,
    // optionally overridden by a write committing on the same edge.
    always_comb begin
        rd1_d = (rd_src1 == '0) ? '0 : regs_q[rd_src1];
        rd2_d = (rd_src2 == '0) ? '0 : regs_q[rd_src2];
`ifdef VX_RF_BYPASS_EN
        if (wr_commit && (wr_rd == rd_src1)) begin
            rd1_d = wr_data;
        end
        if (wr_commit && (wr_rd == rd_src2)) begin
            rd2_d = wr_data;
        end
`else
        // No forwarding: a same-edge write becomes visible one cycle later.
`endif
    end

    // Registered read ports (one-cycle latency).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

endmodule

// File: tb/tb_vx_register_file_spawn_copy.sv
// Bench for vx_register_file_spawn_copy: default instance (32x32, 4 lanes)
// plus a wide instance (64-bit, 64 regs, 8 lanes).
module tb_vx_register_file_spawn_copy;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default instance ----------------
    logic         wr_valid, wr_ready;
    logic [4:0]   wr_rd;
    logic [31:0]  wr_data;
    logic [4:0]   rd_src1, rd_src2;
    logic [31:0]  rd_data1, rd_data2;
    logic         spawn_valid, spawn_ready, spawn_done, busy, state_dbg;
    logic [4:0]   spawn_src_idx;
    logic [127:0] spawn_src_data;

    vx_register_file_spawn_copy u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_rd          (wr_rd),
        .wr_data        (wr_data),
        .rd_src1        (rd_src1),
        .rd_src2        (rd_src2),
        .rd_data1       (rd_data1),
        .rd_data2       (rd_data2),
        .spawn_valid    (spawn_valid),
        .spawn_ready    (spawn_ready),
        .spawn_src_idx  (spawn_src_idx),
        .spawn_src_data (spawn_src_data),
        .spawn_done     (spawn_done),
        .busy           (busy),
        .state_dbg      (state_dbg)
    );

    // Source register file model: reg i holds 0x100 + i.
    always_comb begin
        spawn_src_data = '0;
        for (int l = 0; l < 4; l++) begin
            spawn_src_data[l*32 +: 32] = 32'h100 + 32'(spawn_src_idx) + 32'(l);
        end
    end

    // ---------------- wide instance ----------------
    logic         w_wr_valid, w_wr_ready;
    logic [5:0]   w_wr_rd;
    logic [63:0]  w_wr_data;
    logic [5:0]   w_rd_src1, w_rd_src2;
    logic [63:0]  w_rd_data1, w_rd_data2;
    logic         w_spawn_valid, w_spawn_ready, w_spawn_done, w_busy, w_state_dbg;
    logic [5:0]   w_spawn_src_idx;
    logic [511:0] w_spawn_src_data;

    vx_register_file_spawn_copy #(
        .DATA_WIDTH (64),
        .NUM_REGS   (64),
        .COPY_LANES (8)
    ) u_dut_w (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_valid       (w_wr_valid),
        .wr_ready       (w_wr_ready),
        .wr_rd          (w_wr_rd),
        .wr_data        (w_wr_data),
        .rd_src1        (w_rd_src1),
        .rd_src2        (w_rd_src2),
        .rd_data1       (w_rd_data1),
        .rd_data2       (w_rd_data2),
        .spawn_valid    (w_spawn_valid),
        .spawn_ready    (w_spawn_ready),
        .spawn_src_idx  (w_spawn_src_idx),
        .spawn_src_data (w_spawn_src_data),
        .spawn_done     (w_spawn_done),
        .busy           (w_busy),
        .state_dbg      (w_state_dbg)
    );

    function automatic logic [63:0] wval(input int i);
        return {16'hBEEF, 16'(i), 32'hC0DE0000 + 32'(i)};
    endfunction

    always_comb begin
        w_spawn_src_data = '0;
        for (int l = 0; l < 8; l++) begin
            w_spawn_src_data[l*64 +: 64] = wval(int'(w_spawn_src_idx) + l);
        end
    end

    // ---------------- scoreboard counters ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic read_pair(input logic [4:0] s1, input logic [4:0] s2,
                             input logic [31:0] e1, input logic [31:0] e2, input string nm);
        @(negedge clk);
        rd_src1 = s1;
        rd_src2 = s2;
        @(posedge clk);
        #1;
        check({nm, "_rd1"}, 64'(rd_data1), 64'(e1));
        check({nm, "_rd2"}, 64'(rd_data2), 64'(e2));
    endtask

    task automatic w_read_pair(input int s1, input int s2);
        @(negedge clk);
        w_rd_src1 = 6'(s1);
        w_rd_src2 = 6'(s2);
        @(posedge clk);
        #1;
        check($sformatf("wide_r%0d", s1), w_rd_data1, (s1 == 0) ? 64'h0 : wval(s1));
        check($sformatf("wide_r%0d", s2), w_rd_data2, (s2 == 0) ? 64'h0 : wval(s2));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cnt;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0,        32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'h00000001, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
`ifdef VX_RF_BYPASS_EN
        vecs[2] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd0,  32'h12345678, 32'h0};
`else
        vecs[2] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd0,  32'h0,        32'h0};
`endif
        vecs[3] = '{1'b0, 5'd7,  32'h0,        5'd7,  5'd0,  32'h12345678, 32'h0};
        vecs[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd5,  5'd7,  32'hDEADBEEF, 32'h12345678};
        vecs[5] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd0,  32'hA5A5A5A5, 32'h0};
        vecs[6] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd1,  5'd31, 32'h00000001, 32'hA5A5A5A5};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hCAFEF00D, 32'h0};

        // ---- reset ----
        reset_n = 1'b0;
        wr_valid = 0; wr_rd = 0; wr_data = 0; rd_src1 = 0; rd_src2 = 0; spawn_valid = 0;
        w_wr_valid = 0; w_wr_rd = 0; w_wr_data = 0; w_rd_src1 = 0; w_rd_src2 = 0; w_spawn_valid = 0;
        #3;
        check("rst_wr_ready",    64'(wr_ready), 64'd1);
        check("rst_spawn_ready", 64'(spawn_ready), 64'd1);
        check("rst_busy",        64'(busy), 64'd0);
        check("rst_state",       64'(state_dbg), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rd1",  64'(rd_data1), 64'd0);
        check("post_rst_rd2",  64'(rd_data2), 64'd0);
        check("post_rst_idx",  64'(spawn_src_idx), 64'd0);
        check("post_rst_done", 64'(spawn_done), 64'd0);

        // ---- table-driven write / read vectors ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_valid = vecs[i].wv;
            wr_rd    = vecs[i].wrd;
            wr_data  = vecs[i].wd;
            rd_src1  = vecs[i].s1;
            rd_src2  = vecs[i].s2;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rd1", i), 64'(rd_data1), 64'(vecs[i].e1));
            check($sformatf("vec%0d_rd2", i), 64'(rd_data2), 64'(vecs[i].e2));
            check($sformatf("vec%0d_wr_ready", i), 64'(wr_ready), 64'd1);
        end
        @(negedge clk);
        wr_valid = 1'b0;

        // ---- spawn with a conflicting write ----
        @(negedge clk);
        spawn_valid = 1'b1;
        wr_valid    = 1'b1;
        wr_rd       = 5'd9;
        wr_data     = 32'h999;
        check("conflict_wr_ready_idle", 64'(wr_ready), 64'd1);
        @(posedge clk);
        #1;
        spawn_valid = 1'b0;
        wr_valid    = 1'b0;
        rd_src1     = 5'd1;
        rd_src2     = 5'd30;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("copy%0d_busy", k),     64'(busy), 64'd1);
            check($sformatf("copy%0d_idx", k),      64'(spawn_src_idx), 64'(4 * k));
            check($sformatf("copy%0d_wr_ready", k), 64'(wr_ready), 64'd0);
            check($sformatf("copy%0d_sp_ready", k), 64'(spawn_ready), 64'd0);
            check($sformatf("copy%0d_done", k),     64'(spawn_done), 64'd0);
            if (k == 1) begin
                check("copy_read_old_r1",  64'(rd_data1), 64'h1);
                check("copy_read_old_r30", 64'(rd_data2), 64'h0);
            end
            if (k == 2) begin
                check("copy_read_new_r1", 64'(rd_data1), 64'h101);
            end
            @(negedge clk);
            spawn_valid = (k == 2) || (k == 3);
            @(posedge clk);
            #1;
        end
        check("copy_end_busy",     64'(busy), 64'd0);
        check("copy_end_done",     64'(spawn_done), 64'd1);
        check("copy_end_idx",      64'(spawn_src_idx), 64'd0);
        check("copy_end_wr_ready", 64'(wr_ready), 64'd1);
        @(posedge clk);
        #1;
        check("done_pulse_one_cycle", 64'(spawn_done), 64'd0);
        check("no_restart_busy",      64'(busy), 64'd0);

        for (int i = 0; i < 16; i++) begin
            read_pair(5'(2*i), 5'(2*i+1),
                      (i == 0) ? 32'h0 : 32'h100 + 32'(2*i), 32'h100 + 32'(2*i+1),
                      $sformatf("copied_r%0d", 2*i));
        end

        // ---- reset mid-copy ----
        @(negedge clk);
        spawn_valid = 1'b1;
        @(posedge clk);
        #1;
        spawn_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midcopy_beat3_idx", 64'(spawn_src_idx), 64'd12);
        #2;
        reset_n = 1'b0;
        #1;
        check("midcopy_rst_busy",     64'(busy), 64'd0);
        check("midcopy_rst_state",    64'(state_dbg), 64'd0);
        check("midcopy_rst_idx",      64'(spawn_src_idx), 64'd0);
        check("midcopy_rst_wr_ready", 64'(wr_ready), 64'd1);
        check("midcopy_rst_sp_ready", 64'(spawn_ready), 64'd1);
        check("midcopy_rst_rd1",      64'(rd_data1), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("after_rst%0d_done", k), 64'(spawn_done), 64'd0);
            check($sformatf("after_rst%0d_busy", k), 64'(busy), 64'd0);
        end
        read_pair(5'd1,  5'd12, 32'h0, 32'h0, "cleared_a");
        read_pair(5'd13, 5'd31, 32'h0, 32'h0, "cleared_b");

        // ---- wide instance copy ----
        @(negedge clk);
        w_spawn_valid = 1'b1;
        @(posedge clk);
        #1;
        w_spawn_valid = 1'b0;
        check("wide_busy_start", 64'(w_busy), 64'd1);
        cnt = 0;
        while (w_busy && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("wide_copy_cycles", 64'(cnt), 64'd8);
        check("wide_done",        64'(w_spawn_done), 64'd1);
        check("wide_state",       64'(w_state_dbg), 64'd0);
        for (int i = 0; i < 32; i++) begin
            w_read_pair(2*i, 2*i+1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        tests_failed++;
        $display("FAIL timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
